phase_acc_sweeper: RTL
======================

Name: phase_acc_sweeper

Overview:
- Read-modify-write sequencer that sits directly upstream of the multi-bank operator-state memory, driving both its read port (bankb/addrb/reb) and its write port (banka/addra/wea/dia).
- On each sample-clock-enable it sweeps every (bank, operator) slot once, reads the stored phase accumulator, adds a per-slot increment or clears it on key-on, and writes the result back.
- Each updated value is also streamed out to the downstream waveform/operator stage.
- After reset it zero-fills the memory before accepting sweeps.

Parameters:
- DATA_WIDTH, 19: accumulator and increment width.
- DEPTH, 18: operators per bank (memory depth).
- NUM_BANKS, 2: number of memory banks.
- OUTPUT_DELAY, 1: read latency of the attached memory. Legal values are 0, 1 and 2; 0 means asynchronous read.
- BANK_WIDTH, $clog2(NUM_BANKS): bank index width.
- OP_WIDTH, $clog2(DEPTH): operator index width.

Ports:
- Interface fixed for this block: one clock; synchronous active-high reset, ports named clk and reset.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sample_clk_en  in  1  single-cycle pulse that starts a sweep.
- inc  in  DATA_WIDTH  increment for the slot issued this cycle; sampled when issue_valid=1.
- clr  in  1  key-on clear for the slot issued this cycle; sampled when issue_valid=1.
- issue_valid  out  1  slot issued this cycle.
- issue_bank  out  BANK_WIDTH  bank of issued slot.
- issue_op  out  OP_WIDTH  operator of issued slot.
- busy  out  1  INIT or sweep in progress.
- overrun  out  1  one-cycle pulse: sample_clk_en arrived while busy.
- mem_reb  out  1  memory read enable.
- mem_bankb  out  BANK_WIDTH  memory read bank.
- mem_addrb  out  OP_WIDTH  memory read address.
- mem_dob  in  DATA_WIDTH  memory read data, valid OUTPUT_DELAY cycles after mem_reb.
- mem_wea  out  1  memory write enable.
- mem_banka  out  BANK_WIDTH  memory write bank.
- mem_addra  out  OP_WIDTH  memory write address.
- mem_dia  out  DATA_WIDTH  memory write data.
- acc_valid  out  1  updated-value strobe.
- acc_bank  out  BANK_WIDTH  bank of updated value.
- acc_op  out  OP_WIDTH  operator of updated value.
- acc_out  out  DATA_WIDTH  updated accumulator value.

Behaviour:
- States: INIT, IDLE, ISSUE, DRAIN.
- Reset: state=INIT, bank/op counters=0, pipelines flushed. While reset is high, every output is 0 except busy=1.
- INIT:
  - One write per cycle: mem_wea=1, mem_dia=0, slots in order bank 0 op 0..DEPTH-1, then bank 1, and so on.
  - Takes exactly NUM_BANKS*DEPTH cycles, then goes to IDLE.
  - No reads and no acc_valid during INIT.
- IDLE: busy=0. On sample_clk_en go to ISSUE with counters at 0.
- ISSUE:
  - One slot per cycle, same order as INIT.
  - Outputs: issue_valid=1, mem_reb=1, mem_bankb/mem_addrb = issue_bank/issue_op.
  - inc and clr are captured into a delay line of depth OUTPUT_DELAY, alongside bank/op.
  - After the last slot (bank NUM_BANKS-1, op DEPTH-1): go to DRAIN if OUTPUT_DELAY>0, else IDLE.
- DRAIN: lasts OUTPUT_DELAY cycles, no issue, then IDLE. busy=1 throughout ISSUE and DRAIN.
- Write-back, at cycle t+OUTPUT_DELAY for a slot issued at cycle t:
  - mem_wea=1; mem_banka/mem_addra = that slot.
  - mem_dia = clr_d ? 0 : (mem_dob + inc_d) mod 2^DATA_WIDTH. Wrap silently; no saturation.
  - With OUTPUT_DELAY=0, the write occurs in the issue cycle itself (combinational from mem_dob).
- Output stream:
  - acc_valid, acc_bank, acc_op and acc_out are registered copies of the write-back signals.
  - They appear one cycle after the write, so issue-to-acc_valid latency is OUTPUT_DELAY+1.
- Throughput: one slot per cycle. A sweep occupies busy for NUM_BANKS*DEPTH+OUTPUT_DELAY cycles.
- Hazards: each slot is read and written once per sweep and busy covers the full drain, so no read-after-write forwarding is required.
- sample_clk_en while busy (INIT, ISSUE or DRAIN):
  - Ignored.
  - overrun=1 on the next cycle, for one cycle.
  - No queueing.
- sample_clk_en in the same cycle as the transition to IDLE: ignored (counted as busy).
- Reset mid-sweep:
  - In-flight writes are dropped; mem_wea=0 the cycle after reset is sampled.
  - INIT re-zeroes all slots.
  - No partial acc_valid after reset.
- Idle outputs: mem_reb, mem_wea, issue_valid, acc_valid = 0. Address/data outputs hold their last value.

Test Plan:
- Release reset, OUTPUT_DELAY=1 -> exactly 36 consecutive mem_wea pulses with mem_dia=0, busy=1 for those 36 cycles, then busy=0; no mem_reb during INIT.
- After INIT, one sample_clk_en with inc=5 for all slots -> 36 acc_valid strobes, acc_out=5, in order bank0 op0..17 then bank1; first acc_valid 2 cycles after first issue_valid. A second sweep gives acc_out=10.
- Preload a slot to 2^19-3, apply inc=7 -> acc_out=4 (wrap). Same sweep with clr=1 on bank1 op4 -> that slot's acc_out=0 regardless of inc.
- sample_clk_en pulsed mid-sweep and during INIT -> overrun single-cycle pulse each time; sweep length unchanged at 37 busy cycles; no extra writes.
- Assert reset at sweep slot 10 -> next cycle mem_wea=0 and acc_valid=0; full 36-cycle INIT follows; the next sweep with inc=1 yields acc_out=1 on every slot.
- Repeat the second scenario with OUTPUT_DELAY=0 and OUTPUT_DELAY=2 -> issue-to-acc_valid latency of 1 and 3 cycles; busy length 36 and 38 cycles.

Source files
------------

// File: rtl/phase_acc_sweeper.sv
// phase_acc_sweeper
//   Read-modify-write sequencer for a multi-bank operator-state memory. After
//   reset it zero-fills every slot. Then, on each sample_clk_en, it sweeps
//   every (bank, operator) slot once: it reads the stored phase accumulator,
//   adds the per-slot increment (or clears it on key-on) and writes the
//   result back. Each updated value is also streamed out one cycle after the
//   write.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   sample_clk_en         one-cycle pulse that starts a sweep
//   inc, clr              per-slot increment / key-on clear, sampled with issue_valid
//   issue_valid/bank/op   slot issued this cycle
//   busy, overrun         INIT or sweep in progress / start request dropped
//   mem_reb/bankb/addrb   memory read port
//   mem_dob               memory read data, OUTPUT_DELAY cycles after mem_reb
//   mem_wea/banka/addra/dia  memory write port
//   acc_valid/bank/op/out registered copy of each write-back
module phase_acc_sweeper #(
    parameter int DATA_WIDTH   = 19,
    parameter int DEPTH        = 18,
    parameter int NUM_BANKS    = 2,
    parameter int OUTPUT_DELAY = 1,
    parameter int BANK_WIDTH   = $clog2(NUM_BANKS),
    parameter int OP_WIDTH     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_clk_en,
    input  logic [DATA_WIDTH-1:0] inc,
    input  logic                  clr,
    output logic                  issue_valid,
    output logic [BANK_WIDTH-1:0] issue_bank,
    output logic [OP_WIDTH-1:0]   issue_op,
    output logic                  busy,
    output logic                  overrun,
    output logic                  mem_reb,
    output logic [BANK_WIDTH-1:0] mem_bankb,
    output logic [OP_WIDTH-1:0]   mem_addrb,
    input  logic [DATA_WIDTH-1:0] mem_dob,
    output logic                  mem_wea,
    output logic [BANK_WIDTH-1:0] mem_banka,
    output logic [OP_WIDTH-1:0]   mem_addra,
    output logic [DATA_WIDTH-1:0] mem_dia,
    output logic                  acc_valid,
    output logic [BANK_WIDTH-1:0] acc_bank,
    output logic [OP_WIDTH-1:0]   acc_op,
    output logic [DATA_WIDTH-1:0] acc_out
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

    localparam int                    DLY_N      = (OUTPUT_DELAY == 0) ? 1 : OUTPUT_DELAY;
    localparam logic [BANK_WIDTH-1:0] BANK_LAST  = BANK_WIDTH'(NUM_BANKS - 1);
    localparam logic [OP_WIDTH-1:0]   OP_LAST    = OP_WIDTH'(DEPTH - 1);
    localparam logic [1:0]            DRAIN_LAST = 2'(OUTPUT_DELAY - 1);

    // Phase accumulators wrap modulo 2^DATA_WIDTH; key-on forces zero.
    function automatic logic [DATA_WIDTH-1:0] acc_update(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] step,
        input logic                  clear
    );
        logic [DATA_WIDTH-1:0] sum;
        sum = acc + step;
        return clear ? '0 : sum;
    endfunction

    state_t                state_q;
    logic [BANK_WIDTH-1:0] bank_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [1:0]            drain_cnt_q;
    logic                  overrun_q;
    logic                  last_slot;
    logic                  issue_now;

    assign last_slot = (bank_q == BANK_LAST) && (op_q == OP_LAST);
    assign issue_now = (state_q == ST_ISSUE) && !reset;

    // Sequencer: INIT and ISSUE share the slot counter; counters hold their
    // final value once a pass ends so the read address stays stable in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            bank_q      <= '0;
            op_q        <= '0;
            drain_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= sample_clk_en && (state_q != ST_IDLE);
            case (state_q)
                ST_INIT, ST_ISSUE: begin
                    if (last_slot) begin
                        if (state_q == ST_INIT || OUTPUT_DELAY == 0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= '0;
                        end
                    end else if (op_q == OP_LAST) begin
                        op_q   <= '0;
                        bank_q <= bank_q + BANK_WIDTH'(1);
                    end else begin
                        op_q <= op_q + OP_WIDTH'(1);
                    end
                end
                ST_IDLE: begin
                    if (sample_clk_en) begin
                        state_q <= ST_ISSUE;
                        bank_q  <= '0;
                        op_q    <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Issue stage -> write-back stage: slot tag, inc and clr travel alongside
    // the memory read so they line up with mem_dob.
    logic                  wb_vld;
    logic [BANK_WIDTH-1:0] wb_bank;
    logic [OP_WIDTH-1:0]   wb_op;
    logic [DATA_WIDTH-1:0] wb_inc;
    logic                  wb_clr;

    if (OUTPUT_DELAY == 0) begin : g_nodly
        assign wb_vld  = issue_now;
        assign wb_bank = bank_q;
        assign wb_op   = op_q;
        assign wb_inc  = inc;
        assign wb_clr  = clr;
    end else begin : g_dly
        logic [DLY_N-1:0]      dl_vld_q;
        logic [BANK_WIDTH-1:0] dl_bank_q [DLY_N];
        logic [OP_WIDTH-1:0]   dl_op_q   [DLY_N];
        logic [DATA_WIDTH-1:0] dl_inc_q  [DLY_N];
        logic                  dl_clr_q  [DLY_N];

        always_ff @(posedge clk) begin
            if (reset) begin
                dl_vld_q <= '0;
            end else begin
                dl_vld_q[0] <= issue_now;
                for (int i = 1; i < DLY_N; i++) begin
                    dl_vld_q[i] <= dl_vld_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            dl_bank_q[0] <= bank_q;
            dl_op_q[0]   <= op_q;
            dl_inc_q[0]  <= inc;
            dl_clr_q[0]  <= clr;
            for (int i = 1; i < DLY_N; i++) begin
                dl_bank_q[i] <= dl_bank_q[i-1];
                dl_op_q[i]   <= dl_op_q[i-1];
                dl_inc_q[i]  <= dl_inc_q[i-1];
                dl_clr_q[i]  <= dl_clr_q[i-1];
            end
        end

        assign wb_vld  = dl_vld_q[DLY_N-1];
        assign wb_bank = dl_bank_q[DLY_N-1];
        assign wb_op   = dl_op_q[DLY_N-1];
        assign wb_inc  = dl_inc_q[DLY_N-1];
        assign wb_clr  = dl_clr_q[DLY_N-1];
    end

    // Write-back stage: INIT zero-fill and sweep updates share the write port.
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wr_en;
    logic [BANK_WIDTH-1:0] wr_bank;
    logic [OP_WIDTH-1:0]   wr_op;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BANK_WIDTH-1:0] hold_bank_q;
    logic [OP_WIDTH-1:0]   hold_op_q;
    logic [DATA_WIDTH-1:0] hold_data_q;

    assign wb_data = acc_update(mem_dob, wb_inc, wb_clr);

    always_comb begin
        wr_en   = 1'b0;
        wr_bank = bank_q;
        wr_op   = op_q;
        wr_data = '0;
        if (state_q == ST_INIT) begin
            wr_en = 1'b1;
        end else if (wb_vld) begin
            wr_en   = 1'b1;
            wr_bank = wb_bank;
            wr_op   = wb_op;
            wr_data = wb_data;
        end
        if (reset) begin
            wr_en = 1'b0;
        end
    end

    // Write address/data hold their last value while the port is idle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            hold_bank_q <= wr_bank;
            hold_op_q   <= wr_op;
            hold_data_q <= wr_data;
        end
    end

    // Output stage: registered copy of each sweep write-back.
    logic                  acc_valid_q;
    logic [BANK_WIDTH-1:0] acc_bank_q;
    logic [OP_WIDTH-1:0]   acc_op_q;
    logic [DATA_WIDTH-1:0] acc_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_valid_q <= 1'b0;
        end else begin
            acc_valid_q <= wb_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_vld) begin
            acc_bank_q <= wb_bank;
            acc_op_q   <= wb_op;
            acc_out_q  <= wb_data;
        end
    end

    // Everything reads as zero (busy as one) while reset is held.
    assign issue_valid = issue_now;
    assign issue_bank  = reset ? '0 : bank_q;
    assign issue_op    = reset ? '0 : op_q;
    assign busy        = reset || (state_q != ST_IDLE);
    assign overrun     = overrun_q && !reset;
    assign mem_reb     = issue_now;
    assign mem_bankb   = reset ? '0 : bank_q;
    assign mem_addrb   = reset ? '0 : op_q;
    assign mem_wea     = wr_en;
    assign mem_banka   = reset ? '0 : (wr_en ? wr_bank : hold_bank_q);
    assign mem_addra   = reset ? '0 : (wr_en ? wr_op : hold_op_q);
    assign mem_dia     = reset ? '0 : (wr_en ? wr_data : hold_data_q);
    assign acc_valid   = acc_valid_q && !reset;
    assign acc_bank    = reset ? '0 : acc_bank_q;
    assign acc_op      = reset ? '0 : acc_op_q;
    assign acc_out     = reset ? '0 : acc_out_q;

endmodule
